// File: rtl/ruler_ctrl_pkg.sv
// Constants shared by the ruler LED shifter and its control front end.
package ruler_ctrl_pkg;

   localparam logic DIR_RIGHT = 1'b1;
   localparam logic DIR_LEFT  = 1'b0;

   // Default base step period in clock cycles.
   localparam int unsigned TRIGGER_CNT = 50_000_000;

   // LED patterns at either end of the ruler.
   localparam logic [7:0] RCORNER = 8'h01;
   localparam logic [7:0] LCORNER = 8'h80;

   localparam int NUM_BTN   = 3;
   localparam int BTN_LEFT  = 0;
   localparam int BTN_RIGHT = 1;
   localparam int BTN_PAUSE = 2;

endpackage

// File: rtl/ruler_debounce.sv
// One push button: 2-FF synchroniser, hold-time debounce, press pulse on accepted 0->1.
module ruler_debounce #(
   parameter int unsigned DEBOUNCE_CNT = 1_000_000,
   parameter int unsigned DB_WIDTH     = 20
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic btn_i,
   output logic level_o,
   output logic press_o
);

   localparam logic [DB_WIDTH-1:0] CNT_LAST = DB_WIDTH'(DEBOUNCE_CNT - 1);

   logic                sync1_q;
   logic                sync2_q;
   logic                level_q, level_d;
   logic                press_q, press_d;
   logic [DB_WIDTH-1:0] cnt_q, cnt_d;

   // Any cycle where the synced input agrees with the accepted level restarts the hold count.
   always_comb begin
      level_d = level_q;
      press_d = 1'b0;
      cnt_d   = '0;
      if (sync2_q != level_q) begin
         if (cnt_q == CNT_LAST) begin
            level_d = sync2_q;
            press_d = sync2_q;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         level_q <= 1'b0;
         press_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         sync1_q <= btn_i;
         sync2_q <= sync1_q;
         level_q <= level_d;
         press_q <= press_d;
         cnt_q   <= cnt_d;
      end
   end

   assign level_o = level_q;
   assign press_o = press_q;

endmodule

// File: rtl/ruler_ctrl.sv
// Ruler control front end: debounced left/right/pause buttons, direction/pause
// register and a speed-scaled prescaler producing the one-cycle step strobe.
module ruler_ctrl
   import ruler_ctrl_pkg::*;
#(
   parameter int unsigned TICK_CNT     = TRIGGER_CNT,
   parameter int unsigned DEBOUNCE_CNT = 1_000_000,
   parameter int unsigned CNT_WIDTH    = 26,
   parameter int unsigned DB_WIDTH     = 20
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       btn_left_i,
   input  logic       btn_right_i,
   input  logic       btn_pause_i,
   input  logic [1:0] speed_i,
   output logic       stb_o,
   output logic       dir_o,
   output logic       paused_o
);

   // Last count of a period, i.e. max(TICK_CNT >> speed, 1) - 1.
   function automatic logic [CNT_WIDTH-1:0] period_last(input logic [1:0] speed);
      int unsigned p;
      p = TICK_CNT >> speed;
      if (p == 0) p = 1;
      return CNT_WIDTH'(p - 1);
   endfunction

   logic [NUM_BTN-1:0] btn_raw;
   logic [NUM_BTN-1:0] btn_level_unused;
   logic [NUM_BTN-1:0] btn_press;

   assign btn_raw = {btn_pause_i, btn_right_i, btn_left_i};

   generate
      for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_db
         ruler_debounce #(
            .DEBOUNCE_CNT (DEBOUNCE_CNT),
            .DB_WIDTH     (DB_WIDTH)
         ) u_debounce (
            .clk_i   (clk_i),
            .rst_i   (rst_i),
            .btn_i   (btn_raw[gi]),
            .level_o (btn_level_unused[gi]),
            .press_o (btn_press[gi])
         );
      end
   endgenerate

   logic                 dir_q, dir_d;
   logic                 paused_q, paused_d;
   logic                 stb_q, stb_d;
   logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
   logic [CNT_WIDTH-1:0] last_q, last_d;

   always_comb begin
      dir_d    = dir_q;
      paused_d = paused_q ^ btn_press[BTN_PAUSE];
      if (btn_press[BTN_LEFT] && !btn_press[BTN_RIGHT]) begin
         dir_d = DIR_LEFT;
      end else if (btn_press[BTN_RIGHT] && !btn_press[BTN_LEFT]) begin
         dir_d = DIR_RIGHT;
      end

      cnt_d  = cnt_q;
      last_d = last_q;
      stb_d  = 1'b0;
      // Holding on the entering edge keeps stb_o low whenever paused_o is high;
      // holding on the leaving edge gives a full period after unpause.
      if (paused_q || paused_d) begin
         cnt_d = '0;
      end else if (cnt_q == last_q) begin
         cnt_d  = '0;
         stb_d  = 1'b1;
         last_d = period_last(speed_i);
      end else begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         dir_q    <= DIR_RIGHT;
         paused_q <= 1'b0;
         stb_q    <= 1'b0;
         cnt_q    <= '0;
         last_q   <= period_last(speed_i);
      end else begin
         dir_q    <= dir_d;
         paused_q <= paused_d;
         stb_q    <= stb_d;
         cnt_q    <= cnt_d;
         last_q   <= last_d;
      end
   end

   assign stb_o    = stb_q;
   assign dir_o    = dir_q;
   assign paused_o = paused_q;

endmodule

// File: tb/tb_ruler_ctrl.sv
// Randomised and directed bench for ruler_ctrl against a cycle-level behavioural model.
module tb_ruler_ctrl;

   localparam int TICK = 8;
   localparam int DB   = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       bl = 1'b0, br = 1'b0, bp = 1'b0;
   logic [1:0] speed = 2'd0;
   logic       stb, dir, paused;

   always #5 clk = ~clk;

   ruler_ctrl #(
      .TICK_CNT     (TICK),
      .DEBOUNCE_CNT (DB),
      .CNT_WIDTH    (4),
      .DB_WIDTH     (3)
   ) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .btn_left_i  (bl),
      .btn_right_i (br),
      .btn_pause_i (bp),
      .speed_i     (speed),
      .stb_o       (stb),
      .dir_o       (dir),
      .paused_o    (paused)
   );

   int n_checks = 0;
   int n_fails  = 0;

   task automatic chk(input string tag, input int got, input int exp);
      n_checks++;
      if (got !== exp) begin
         n_fails++;
         $display("FAIL %s: got %0d, expected %0d at t=%0t", tag, got, exp, $time);
      end
   endtask

   // Model: raw sample history per button (bit j = sample j edges ago); a level
   // flips once the D samples that have reached the synchroniser output all differ from it.
   bit [15:0] hist [3];
   bit        m_lvl [3];
   bit        m_pend [3];
   bit        m_dir, m_paused, m_stb;
   int        m_since, m_p;

   function automatic int p_of(input int s);
      int p;
      p = TICK >> s;
      return (p == 0) ? 1 : p;
   endfunction

   task automatic model_step();
      bit raw [3];
      bit np, nd, diff;
      raw[0] = bl; raw[1] = br; raw[2] = bp;
      if (rst) begin
         for (int b = 0; b < 3; b++) begin
            hist[b] = '0; m_lvl[b] = 0; m_pend[b] = 0;
         end
         m_dir = 1; m_paused = 0; m_stb = 0; m_since = 0; m_p = p_of(speed);
         return;
      end
      np = m_paused ^ m_pend[2];
      nd = m_dir;
      if (m_pend[0] && !m_pend[1]) nd = 0;
      if (m_pend[1] && !m_pend[0]) nd = 1;
      m_stb = 0;
      if (m_paused || np) begin
         m_since = 0;
      end else begin
         m_since++;
         if (m_since == m_p) begin
            m_stb = 1; m_since = 0; m_p = p_of(speed);
         end
      end
      m_dir = nd; m_paused = np;
      for (int b = 0; b < 3; b++) begin
         hist[b] = {hist[b][14:0], raw[b]};
         diff = 1;
         for (int j = 2; j <= DB + 1; j++) if (hist[b][j] == m_lvl[b]) diff = 0;
         m_pend[b] = 0;
         if (diff) begin
            m_lvl[b] = ~m_lvl[b];
            m_pend[b] = m_lvl[b];
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
      chk("stb", stb, m_stb);
      chk("dir", dir, m_dir);
      chk("paused", paused, m_paused);
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   int k;

   initial begin
      // 1. reset and free-running strobe
      run(2);
      rst = 0;
      chk("reset_dir", dir, 1);
      chk("reset_paused", paused, 0);
      chk("reset_stb", stb, 0);
      k = 0;
      for (int i = 0; i < 24; i++) begin tick(); if (stb) k++; end
      chk("stb_count_24", k, 3);
      $display("scenario 1: reset and strobes, %0d strobes in 24 cycles", k);

      // 2. left press accepted at edge 7, short right glitch ignored
      bl = 1;
      run(6);
      chk("dir_before_edge7", dir, 1);
      tick();
      chk("dir_edge7", dir, 0);
      bl = 0; run(8);
      br = 1; run(3); br = 0; run(10);
      chk("glitch_ignored", dir, 0);
      $display("scenario 2: left press dir=%0d after glitch", dir);

      // 3. simultaneous left+right, then right alone
      bl = 1; br = 1; run(10);
      chk("both_pressed", dir, 0);
      bl = 0; br = 0; run(10);
      br = 1; run(10);
      chk("right_press", dir, 1);
      br = 0; run(10);
      $display("scenario 3: simultaneous then right dir=%0d", dir);

      // 4. pause, no strobes, unpause gap
      bp = 1; run(8); bp = 0;
      chk("paused_set", paused, 1);
      k = 0;
      for (int i = 0; i < 50; i++) begin tick(); if (stb) k++; end
      chk("no_stb_paused", k, 0);
      bp = 1;
      k = 0;
      while (paused && k < 20) begin tick(); k++; end
      chk("unpause_seen", paused, 0);
      k = 0;
      do begin tick(); k++; end while (!stb && k < 20);
      chk("unpause_gap", k, 8);
      bp = 0; run(10);
      $display("scenario 4: pause/unpause gap=%0d", k);

      // 5. speed change mid period
      k = 0;
      while (!stb && k < 20) begin tick(); k++; end
      chk("stb_found", stb, 1);
      run(3);
      speed = 3;
      k = 0;
      do begin tick(); k++; end while (!stb && k < 20);
      chk("gap_old_period", k, 5);
      tick(); chk("p1_stb_a", stb, 1);
      tick(); chk("p1_stb_b", stb, 1);
      speed = 2; run(12);
      $display("scenario 5: speed change gap=%0d", k);

      // 6. reset during a debounce count and during pause
      speed = 0;
      bl = 1; run(3);
      rst = 1; tick(); rst = 0; bl = 0;
      chk("rst_stb", stb, 0);
      chk("rst_dir", dir, 1);
      run(12);
      chk("partial_rejected", dir, 1);
      bp = 1; run(8); bp = 0; run(4);
      chk("paused_again", paused, 1);
      rst = 1; tick(); rst = 0;
      chk("rst_unpause", paused, 0);
      chk("rst_stb2", stb, 0);
      run(10);
      $display("scenario 6: reset mid-debounce and mid-pause");

      // random phase
      for (int s = 0; s < 300; s++) begin
         bl = ($urandom_range(0, 3) == 0);
         br = ($urandom_range(0, 3) == 0);
         bp = ($urandom_range(0, 5) == 0);
         if ($urandom_range(0, 7) == 0) speed = 2'($urandom_range(0, 3));
         rst = ($urandom_range(0, 39) == 0);
         if (rst) begin tick(); rst = 0; end
         run($urandom_range(1, 9));
      end
      $display("random phase: 300 segments done");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
